// File: rtl/spi_flash_read_seq_if.sv
// Bus bundle for spi_flash_read_seq: read request, read-data stream,
// status flags and the APB master port toward the SPI controller.
interface spi_flash_read_seq_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  // read request
  logic                      req_valid;
  logic                      req_ready;
  logic [23:0]               req_addr;
  logic [10:0]               req_len;
  // read-data stream
  logic [31:0]               data_o;
  logic                      data_valid_o;
  logic                      data_ready_i;
  // status
  logic                      done_o;
  logic                      err_o;
  // APB master
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_valid, req_addr, req_len, data_ready_i, PRDATA, PREADY, PSLVERR,
    output req_ready, data_o, data_valid_o, done_o, err_o,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_addr, req_len, data_ready_i, PRDATA, PREADY, PSLVERR,
    input  req_ready, data_o, data_valid_o, done_o, err_o,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/spi_flash_read_seq.sv
// Sequencer that programs an APB-attached SPI master to perform a flash
// read, then polls its RX FIFO and streams the received words out.
module spi_flash_read_seq #(
  parameter int         APB_ADDR_WIDTH = 12,
  parameter logic [7:0] READ_OPCODE    = 8'h03,
  parameter int         SPI_BASE       = 0
) (
  input logic                   HCLK,
  input logic                   HRESET,
  spi_flash_read_seq_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_ADR,
    S_WR_LEN,
    S_WR_CTRL,
    S_POLL,
    S_RD_FIFO,
    S_PUSH,
    S_DONE
  } state_t;

  localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL = APB_ADDR_WIDTH'(SPI_BASE + 32'h00);
  localparam logic [APB_ADDR_WIDTH-1:0] A_CMD  = APB_ADDR_WIDTH'(SPI_BASE + 32'h08);
  localparam logic [APB_ADDR_WIDTH-1:0] A_ADDR = APB_ADDR_WIDTH'(SPI_BASE + 32'h0C);
  localparam logic [APB_ADDR_WIDTH-1:0] A_LEN  = APB_ADDR_WIDTH'(SPI_BASE + 32'h10);
  localparam logic [APB_ADDR_WIDTH-1:0] A_RXF  = APB_ADDR_WIDTH'(SPI_BASE + 32'h20);

  state_t      state_q, state_d;
  logic        access_q, access_d;   // 0: APB SETUP phase, 1: APB ACCESS phase
  logic [23:0] addr_q;
  logic [10:0] len_q;
  logic [10:0] cnt_q;
  logic [31:0] data_q;
  logic        err_q;

  logic apb_state;
  logic xfer_done;
  logic req_fire;
  logic push_fire;

  // Decode of the current cycle's handshakes
  always_comb begin
    apb_state = (state_q == S_WR_CMD)  || (state_q == S_WR_ADR) ||
                (state_q == S_WR_LEN)  || (state_q == S_WR_CTRL) ||
                (state_q == S_POLL)    || (state_q == S_RD_FIFO);
    xfer_done = apb_state && access_q && bus.PREADY;
    req_fire  = (state_q == S_IDLE) && bus.req_valid;
    push_fire = (state_q == S_PUSH) && bus.data_ready_i;
  end

  // State and APB phase register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      access_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
    end
  end

  // Next-state logic; every APB state is exactly one SETUP+ACCESS pair
  always_comb begin
    state_d  = state_q;
    access_d = access_q;
    if (apb_state) begin
      if (!access_q) begin
        access_d = 1'b1;
      end else if (bus.PREADY) begin
        access_d = 1'b0;
        if (bus.PSLVERR) begin
          state_d = S_DONE;
        end else begin
          case (state_q)
            S_WR_CMD:  state_d = S_WR_ADR;
            S_WR_ADR:  state_d = S_WR_LEN;
            S_WR_LEN:  state_d = S_WR_CTRL;
            S_WR_CTRL: state_d = S_POLL;
            S_POLL:    if (bus.PRDATA[23:16] != '0) state_d = S_RD_FIFO;
            S_RD_FIFO: state_d = S_PUSH;
            default:   state_d = S_IDLE;
          endcase
        end
      end
    end else begin
      case (state_q)
        S_IDLE:  if (bus.req_valid) state_d = (bus.req_len == '0) ? S_DONE : S_WR_CMD;
        S_PUSH:  if (bus.data_ready_i) state_d = (cnt_q <= 11'd1) ? S_DONE : S_POLL;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Request latch, remaining-word counter, read data and sticky error
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (req_fire) begin
        addr_q <= bus.req_addr;
        len_q  <= bus.req_len;
        cnt_q  <= bus.req_len;
        err_q  <= 1'b0;
      end else if (xfer_done && bus.PSLVERR) begin
        err_q  <= 1'b1;
      end
      if (push_fire) cnt_q <= cnt_q - 11'd1;
      if (xfer_done && !bus.PSLVERR && (state_q == S_RD_FIFO)) data_q <= bus.PRDATA;
    end
  end

  // Output decode; APB signals are pure functions of registered state
  always_comb begin
    bus.req_ready    = (state_q == S_IDLE) && !HRESET;
    bus.data_valid_o = (state_q == S_PUSH);
    bus.done_o       = (state_q == S_DONE);
    bus.data_o       = data_q;
    bus.err_o        = err_q;
    bus.PSEL         = apb_state;
    bus.PENABLE      = apb_state && access_q;
    bus.PWRITE       = 1'b0;
    bus.PADDR        = '0;
    bus.PWDATA       = '0;
    case (state_q)
      S_WR_CMD: begin
        bus.PWRITE = 1'b1;
        bus.PADDR  = A_CMD;
        bus.PWDATA = {READ_OPCODE, 24'h00_0000};
      end
      S_WR_ADR: begin
        bus.PWRITE = 1'b1;
        bus.PADDR  = A_ADDR;
        bus.PWDATA = {addr_q, 8'h00};
      end
      S_WR_LEN: begin
        // data_len = words*32 in the top half, then addr_len=24, cmd_len=8
        bus.PWRITE = 1'b1;
        bus.PADDR  = A_LEN;
        bus.PWDATA = {len_q, 5'b0_0000, 2'b00, 6'd24, 2'b00, 6'd8};
      end
      S_WR_CTRL: begin
        bus.PWRITE = 1'b1;
        bus.PADDR  = A_CTRL;
        bus.PWDATA = 32'h0000_0101;
      end
      S_POLL:    bus.PADDR = A_CTRL;
      S_RD_FIFO: bus.PADDR = A_RXF;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Randomised scoreboard bench for spi_flash_read_seq with an APB slave model.
module tb_spi_flash_read_seq;
  localparam int         AW   = 12;
  localparam logic [7:0] OPC  = 8'h03;
  localparam int         BASE = 'h100;
  localparam logic [31:0] A_ST  = 32'(BASE + 'h00);
  localparam logic [31:0] A_CMD = 32'(BASE + 'h08);
  localparam logic [31:0] A_ADR = 32'(BASE + 'h0C);
  localparam logic [31:0] A_LEN = 32'(BASE + 'h10);
  localparam logic [31:0] A_RX  = 32'(BASE + 'h20);
  localparam int K_WR = 0, K_RD = 1, K_DAT = 2, K_DONE = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_flash_read_seq_if #(.APB_ADDR_WIDTH(AW)) bus ();

  spi_flash_read_seq #(
    .APB_ADDR_WIDTH(AW),
    .READ_OPCODE   (OPC),
    .SPI_BASE      (BASE)
  ) dut (
    .HCLK  (clk),
    .HRESET(rst),
    .bus   (bus.master)
  );

  initial forever #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  evt_t        exp_q[$];
  int          poll_q[$];
  logic [31:0] rx_q[$];
  int          acc_total = 0;
  int          base_idx = 0;
  int          err_cfg = -1;
  int          force_wait_rel = -1;
  int          wait_max = 0;
  bit          ready_mode = 1'b1;
  int          hold_cycles = 0;
  int          last_valid_len = 0;
  bit          mon_en = 1'b0;

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h", name, act, req);
    end
  endfunction

  function automatic void push_exp(input int k, input logic [31:0] a, input logic [31:0] d);
    evt_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // Reference model: the externally visible event sequence of one request
  task automatic model_request(input logic [23:0] a, input int len, input int err_rel,
                               input int z_first, input int zmax);
    logic [31:0] wr_addr[4];
    logic [31:0] wr_data[4];
    int          z;
    logic [31:0] d;
    if (len == 0) begin
      push_exp(K_DONE, 0, 0);
      return;
    end
    wr_addr[0] = A_CMD; wr_data[0] = 32'(OPC) * 32'h0100_0000;
    wr_addr[1] = A_ADR; wr_data[1] = 32'(a) * 32'd256;
    wr_addr[2] = A_LEN; wr_data[2] = 32'(len * 32) * 32'd65536 + 32'd24 * 32'd256 + 32'd8;
    wr_addr[3] = A_ST;  wr_data[3] = 32'h0000_0101;
    for (int i = 0; i < 4; i++) begin
      push_exp(K_WR, wr_addr[i], wr_data[i]);
      if (err_rel == i) begin
        push_exp(K_DONE, 0, 1);
        return;
      end
    end
    for (int w = 0; w < len; w++) begin
      z = (w == 0 && z_first >= 0) ? z_first : int'($urandom_range(0, zmax));
      poll_q.push_back(z);
      for (int p = 0; p <= z; p++) push_exp(K_RD, A_ST, 0);
      push_exp(K_RD, A_RX, 0);
      d = $urandom;
      rx_q.push_back(d);
      push_exp(K_DAT, 0, d);
    end
    push_exp(K_DONE, 0, 0);
  endtask

  // APB slave: random wait states, scripted STATUS/RXFIFO responses, error injection
  initial begin
    int          waits_left = 0;
    int          zeros_left = -1;
    int          rel = 0;
    logic [31:0] d;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        zeros_left  = -1;
        waits_left  = 0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
      end else if (bus.PSEL && !bus.PENABLE) begin
        rel         = acc_total - base_idx;
        waits_left  = (rel == force_wait_rel) ? 5 : int'($urandom_range(0, wait_max));
        bus.PREADY  = 1'($urandom_range(0, 1));
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = $urandom;
      end else if (bus.PSEL && bus.PENABLE) begin
        if (waits_left > 0) begin
          waits_left--;
          bus.PREADY  = 1'b0;
          bus.PSLVERR = 1'($urandom_range(0, 1));
          d = $urandom;
          d[23:16] = 8'($urandom_range(1, 255));
          bus.PRDATA = d;
        end else begin
          bus.PREADY  = 1'b1;
          bus.PSLVERR = (rel == err_cfg);
          d = $urandom;
          if (!bus.PWRITE && 32'(bus.PADDR) == A_ST) begin
            if (zeros_left < 0) zeros_left = (poll_q.size() != 0) ? poll_q.pop_front() : 0;
            if (zeros_left > 0) begin
              d[23:16] = 8'h00;
              zeros_left--;
            end else begin
              d[23:16] = 8'($urandom_range(1, 255));
              zeros_left = -1;
            end
          end else if (!bus.PWRITE && 32'(bus.PADDR) == A_RX) begin
            d = (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
          end
          bus.PRDATA = d;
          acc_total++;
        end
      end else begin
        bus.PREADY  = 1'($urandom_range(0, 1));
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = $urandom;
      end
    end
  end

  // Stream sink: optional initial hold, then always-ready or random ready
  initial begin
    int vcnt = 0;
    bus.data_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        vcnt = 0;
        bus.data_ready_i = 1'b0;
      end else if (bus.data_valid_o) begin
        vcnt++;
        if (vcnt > hold_cycles) bus.data_ready_i = ready_mode ? 1'b1 : 1'($urandom_range(0, 1));
        else                    bus.data_ready_i = 1'b0;
        if (bus.data_ready_i) begin
          last_valid_len = vcnt;
          vcnt = 0;
        end
      end else begin
        vcnt = 0;
        bus.data_ready_i = ready_mode ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic got_evt(input int kind, input logic [31:0] a, input logic [31:0] d);
    evt_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, wanted none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != a || (kind != K_RD && e.data != d)) begin
        n_err++;
        $display("FAIL event: got kind=%0d addr=%h data=%h, wanted kind=%0d addr=%h data=%h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: protocol holds plus scoreboard comparison of every observed event
  initial begin
    bit          have_prev = 1'b0;
    bit          p_psel = 1'b0, p_pen = 1'b0, p_rdy = 1'b0, p_wr = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0, p_data = '0;
    bit          p_valid = 1'b0, p_ready = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!mon_en || rst) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev && p_psel && (!p_pen || !p_rdy))
          chk(bus.PSEL && bus.PENABLE && 32'(bus.PADDR) == p_addr && bus.PWRITE == p_wr &&
              bus.PWDATA == p_wd, "apb_hold", 32'(bus.PADDR), p_addr);
        if (have_prev && p_valid && !p_ready)
          chk(bus.data_valid_o && bus.data_o == p_data, "push_hold", bus.data_o, p_data);
        if (bus.data_valid_o || bus.done_o)
          chk(!bus.PSEL, "apb_quiet", 32'(bus.PSEL), 0);
        if (bus.PSEL && bus.PENABLE && bus.PREADY)
          got_evt(bus.PWRITE ? K_WR : K_RD, 32'(bus.PADDR), bus.PWRITE ? bus.PWDATA : 32'h0);
        if (bus.data_valid_o && bus.data_ready_i) got_evt(K_DAT, 0, bus.data_o);
        if (bus.done_o) got_evt(K_DONE, 0, 32'(bus.err_o));
        have_prev = 1'b1;
        p_psel  = bus.PSEL;  p_pen = bus.PENABLE; p_rdy = bus.PREADY; p_wr = bus.PWRITE;
        p_addr  = 32'(bus.PADDR); p_wd = bus.PWDATA;
        p_valid = bus.data_valid_o; p_ready = bus.data_ready_i; p_data = bus.data_o;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({bus.PSEL, bus.PENABLE, bus.PWRITE} == 3'b000, {tag, "_apb_ctl"},
        32'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 0);
    chk(bus.PADDR == '0 && bus.PWDATA == '0, {tag, "_apb_bus"}, bus.PWDATA | 32'(bus.PADDR), 0);
    chk(bus.data_o == '0, {tag, "_data"}, bus.data_o, 0);
    chk({bus.data_valid_o, bus.done_o, bus.err_o, bus.req_ready} == 4'b0000, {tag, "_flags"},
        32'({bus.data_valid_o, bus.done_o, bus.err_o, bus.req_ready}), 0);
  endtask

  task automatic handshake(input logic [23:0] a, input logic [10:0] l, input bit noise);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    #4;
    while (!bus.req_ready && n < 500) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (!bus.req_ready) chk(1'b0, "req_ready_timeout", 0, 1);
    base_idx = acc_total;
    @(negedge clk);
    if (noise) begin
      repeat (2) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = 24'($urandom);
        bus.req_len   = 11'($urandom);
        @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic issue(input logic [23:0] a, input int len, input int err, input int z_first,
                       input int zmax, input bit noise);
    err_cfg = err;
    model_request(a, len, err, z_first, zmax);
    handshake(a, 11'(len), noise);
  endtask

  task automatic flush_and_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    poll_q.delete();
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk(1'b0, {"timeout_", tag}, 32'(exp_q.size()), 0);
      flush_and_reset();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e, l;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;

    repeat (2) @(negedge clk);
    #4;
    check_reset("rst_init");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(bus.req_ready == 1'b1, "ready_after_rst", 32'(bus.req_ready), 1);
    mon_en = 1'b1;

    // reference read: 3 empty polls on first word, two words streamed
    wait_max = 0; ready_mode = 1'b1; hold_cycles = 0; force_wait_rel = -1;
    issue(24'h001234, 2, -1, 3, 0, 1'b0);
    wait_idle("basic");
    chk(bus.err_o == 1'b0, "basic_err", 32'(bus.err_o), 0);

    // five wait states on the ADDR write
    force_wait_rel = 1;
    issue(24'($urandom), 1, -1, 0, 0, 1'b1);
    wait_idle("addr_wait");
    force_wait_rel = -1;

    // sink stalls four cycles on the pushed word
    hold_cycles = 4;
    issue(24'($urandom), 1, -1, 1, 0, 1'b0);
    wait_idle("push_hold");
    chk(last_valid_len == 5, "push_hold_len", 32'(last_valid_len), 5);
    hold_cycles = 0;

    // sink already ready on entry
    issue(24'($urandom), 1, -1, 0, 0, 1'b0);
    wait_idle("push_fast");
    chk(last_valid_len == 1, "push_fast_len", 32'(last_valid_len), 1);

    // slave error on the LEN write
    issue(24'($urandom), 3, 2, 0, 0, 1'b0);
    wait_idle("slverr");
    chk(bus.err_o == 1'b1, "err_sticky", 32'(bus.err_o), 1);

    // zero-length request: immediate done, error flag cleared
    issue(24'($urandom), 0, -1, 0, 0, 1'b0);
    #4;
    chk(bus.done_o == 1'b1, "len0_done", 32'(bus.done_o), 1);
    chk(bus.err_o == 1'b0, "err_clear", 32'(bus.err_o), 0);
    wait_idle("len0");

    // randomised traffic
    wait_max = 2; ready_mode = 1'b0;
    for (int i = 0; i < 25; i++) begin
      e = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      l = int'($urandom_range(0, 6));
      issue(24'($urandom), l, e, -1, 3, 1'b1);
      wait_idle("random");
      chk(bus.err_o == (e >= 0 && l > 0), "rand_err", 32'(bus.err_o), 32'(e >= 0 && l > 0));
    end

    // asynchronous reset while polling STATUS
    wait_max = 0; ready_mode = 1'b1;
    issue(24'($urandom), 2, -1, 8, 0, 1'b0);
    begin
      int n = 0;
      bit found = 1'b0;
      while (!found && n < 200) begin
        @(negedge clk);
        #2;
        found = bus.PSEL && !bus.PWRITE && 32'(bus.PADDR) == A_ST;
        n++;
      end
      chk(found, "poll_seen", 32'(found), 1);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("rst_poll");
    exp_q.delete();
    poll_q.delete();
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk(bus.req_ready == 1'b1, "ready_after_rst2", 32'(bus.req_ready), 1);
    mon_en = 1'b1;

    // clean request after the mid-sequence reset
    issue(24'($urandom), 2, -1, 1, 1, 1'b0);
    wait_idle("post_rst");

    chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_flash_read_seq.md
SPI_FLASH_READ_SEQ -- requirements
Module: spi_flash_read_seq

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, width of PADDR.
REQ-002 SHALL have parameter READ_OPCODE, default 8'h03, flash read opcode.
REQ-003 SHALL have parameter SPI_BASE, default 0, base address of the SPI master added to every register offset.
REQ-004 SHALL have ports: HCLK in 1 clock; HRESET in 1 reset, asynchronous, active-high (one clock, async active-high reset, as decided).
REQ-005 SHALL have ports: req_valid in 1, req_ready out 1, req_addr in 24 flash byte address, req_len in 11 number of 32-bit words.
REQ-006 SHALL have ports: data_o out 32, data_valid_o out 1, data_ready_i in 1 (read-data stream).
REQ-007 SHALL have ports: done_o out 1 one-cycle completion pulse, err_o out 1 sticky APB error flag.
REQ-008 SHALL have APB master ports: PADDR out APB_ADDR_WIDTH, PWDATA out 32, PWRITE out 1, PSEL out 1, PENABLE out 1, PRDATA in 32, PREADY in 1, PSLVERR in 1.

Function
REQ-009 SHALL use SPI master offsets: STATUS/CTRL 0x00, CMD 0x08, ADDR 0x0C, LEN 0x10, RXFIFO 0x20.
REQ-010 SHALL run every APB access as SETUP (PSEL=1, PENABLE=0, one cycle), then ACCESS (PSEL=1, PENABLE=1) held until PREADY=1; PADDR/PWRITE/PWDATA stable across both phases; PSEL=0 between accesses.
REQ-011 SHALL assert req_ready only in IDLE; handshake on req_valid&req_ready latches req_addr and req_len.
REQ-012 SHALL, for req_len=0, go IDLE->DONE with no APB traffic.
REQ-013 SHALL sequence states IDLE, WR_CMD, WR_ADR, WR_LEN, WR_CTRL, POLL, RD_FIFO, PUSH, DONE; each WR_/POLL/RD_ state is one APB access, advancing when PREADY=1 in ACCESS.
REQ-014 WR_CMD SHALL write {READ_OPCODE,24'h0} to CMD.
REQ-015 WR_ADR SHALL write {req_addr,8'h00} to ADDR.
REQ-016 WR_LEN SHALL write {data_len[15:0], 2'b0, addr_len=6'd24, 2'b0, cmd_len=6'd8} with data_len = req_len*32 (16 bits, no overflow since req_len <= 2047).
REQ-017 WR_CTRL SHALL write 32'h0000_0101 to STATUS/CTRL (rd=1, csreg=4'b0001).
REQ-018 POLL SHALL read STATUS; PRDATA[23:16]!=0 -> RD_FIFO, else repeat POLL (new SETUP next cycle).
REQ-019 RD_FIFO SHALL read RXFIFO, capture PRDATA into data_o, go to PUSH.
REQ-020 PUSH SHALL hold data_valid_o=1 with data_o stable until data_ready_i=1; on handshake decrement remaining-word counter; counter 0 -> DONE, else -> POLL.
REQ-021 data_ready_i already high on PUSH entry SHALL complete the transfer that cycle (data_valid_o high for exactly one cycle).
REQ-022 DONE SHALL assert done_o for one cycle and return to IDLE.
REQ-023 PSLVERR=1 with PREADY=1 in ACCESS SHALL set err_o, abort the sequence, skip to DONE; err_o clears only on next accepted request or reset.
REQ-024 req_valid while busy SHALL be ignored (req_ready=0); latched request unaffected.
REQ-025 SHALL not issue any APB access while in PUSH or DONE.

Reset
REQ-026 HRESET=1 SHALL asynchronously force IDLE, counter 0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, data_o=0, data_valid_o=0, done_o=0, err_o=0, req_ready=0 while reset asserted, 1 from first cycle after release.
REQ-027 Reset mid-APB-access SHALL drop PSEL/PENABLE immediately; no partial transfer resumes.

Verification
REQ-028 req_addr=24'h001234, req_len=2, PREADY=1 always -> writes CMD=0x03000000, ADDR=0x00123400, LEN=0x00401808, CTRL=0x00000101, in order, each 2 cycles.
REQ-029 Same request, STATUS[23:16]=0 for 3 polls then 1 -> 4 STATUS reads, then RXFIFO read, data_o=PRDATA, two words streamed, one done_o pulse.
REQ-030 PREADY low 5 cycles in WR_ADR ACCESS -> PADDR/PWDATA/PENABLE held 5 extra cycles, no duplicate write.
REQ-031 data_ready_i=0 for 4 cycles in PUSH -> data_valid_o high 5 cycles, data_o constant, no APB activity.
REQ-032 PSLVERR=1 on WR_LEN -> err_o=1, no CTRL write, done_o pulse, next request clears err_o.
REQ-033 req_len=0 -> done_o one cycle after handshake, PSEL never asserted; HRESET pulse during POLL -> all outputs to REQ-026 values same cycle.
